mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, giving the width of the performance counters.
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports Op  input  6 and Funct  input  6, the opcode and funct fields taken from the instruction register.
REQ-005 SHALL have port Zero  input  1, the ALU zero flag.
REQ-006 SHALL have outputs PCWrite 1, IRWrite 1, RegWrite 1 and MemWrite 1, each a write-enable strobe.
REQ-007 SHALL have outputs EXTOp 1, ALUSrc 1, ALUOp 4, NPCOp 4, GPRSel 2 and WDSel 2, carrying the datapath selects.
REQ-008 SHALL have outputs state  output  3, the current FSM state, and instr_done  output  1, a retire pulse.
REQ-009 SHALL have outputs cyc_cnt  output  CNT_W and ret_cnt  output  CNT_W, the performance counters.

Function
REQ-010 SHALL implement states IF=0, ID=1, EX=2, MEM=3 and WB=4; all other encodings SHALL go to IF on the next edge.
REQ-011 SHALL assert IRWrite only in IF; IF SHALL always go to ID.
REQ-012 ID transitions: j or jal goes to IF; an unsupported opcode goes to IF as a NOP; every other opcode goes to EX.
REQ-013 EX transitions: beq and jr go to IF; lw and sw go to MEM; R-type, addi and ori go to WB.
REQ-014 MEM transitions: sw goes to IF with MemWrite=1; lw goes to WB.
REQ-015 WB SHALL assert RegWrite=1 and go to IF.
REQ-016 jal SHALL assert RegWrite=1 in ID with GPRSel=2 (r31) and WDSel=2 (PC+4).
REQ-017 PCWrite SHALL pulse for exactly one cycle, in the last state of each instruction, with NPCOp valid; PC SHALL hold constant during an instruction.
REQ-018 NPCOp encoding: 0 = PC+4, 1 = branch, 2 = jump, 3 = jr. beq in EX SHALL use NPCOp=1 if Zero=1, else NPCOp=0.
REQ-019 ALUOp encoding: 0 nop, 1 add, 2 sub, 3 and, 4 or, 5 slt, 6 sll, 7 srl.
REQ-020 ALUOp decode: R-type from Funct (100000, 100010, 100100, 100101, 101010, 000000, 000010); addi, lw and sw use add; ori uses or; beq uses sub.
REQ-021 ALUSrc=1 and GPRSel=1 (rt) for addi, ori and lw; EXTOp=1 for addi, lw, sw and beq; EXTOp=0 for ori.
REQ-022 WDSel=1 for lw in WB; otherwise WDSel=0 except for jal.
REQ-023 All outputs SHALL be combinational from state, Op, Funct and Zero; strobes SHALL be 0 in every state not named above.
REQ-024 Cycle counts SHALL be: j, jal and NOP 2; beq and jr 3; R-type, addi, ori and sw 4; lw 5.
REQ-025 instr_done SHALL equal PCWrite.

Reset
REQ-026 rst=0 SHALL force state=IF and cyc_cnt=ret_cnt=0 immediately, without waiting for a clock edge.
REQ-027 While rst=0, PCWrite, IRWrite, RegWrite and MemWrite SHALL be 0 and all selects SHALL be 0.
REQ-028 Reset asserted mid-instruction SHALL abort the instruction with no partial write; execution SHALL restart in IF after release.

Configuration
REQ-029 With MC_CTRL_PERF_EN defined: cyc_cnt SHALL increment every cycle out of reset and ret_cnt SHALL increment on each instr_done; both SHALL wrap modulo 2^CNT_W.
REQ-030 Without MC_CTRL_PERF_EN: both ports SHALL remain present and constant 0, and no counter flops SHALL be synthesized.

Verification
REQ-031 Op=000000, Funct=100000 (add): state sequence 0,1,2,4,0; RegWrite=1 only in WB with ALUOp=1, GPRSel=0; PCWrite=1 only in WB with NPCOp=0.
REQ-032 Op=100011 (lw): sequence 0,1,2,3,4; MemWrite=0 throughout; WB has WDSel=1, GPRSel=1; ret_cnt goes 0 to 1 after 5 cycles.
REQ-033 Op=000100 (beq), Zero=1 then Zero=0: EX PCWrite=1 with NPCOp=1, then NPCOp=0; 3 cycles each.
REQ-034 Op=000011 (jal): ID has RegWrite=1, GPRSel=2, WDSel=2, PCWrite=1, NPCOp=2; 2 cycles.
REQ-035 sw issued, rst=0 driven in MEM before the edge: MemWrite never 1; state=0 immediately; cyc_cnt=0.
REQ-036 With MC_CTRL_PERF_EN, CNT_W=4, 17 cycles out of reset: cyc_cnt=1 (wrap); without the macro, cyc_cnt=0.

Source files
------------

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS-subset control unit.
//   Walks the datapath through IF/ID/EX/MEM/WB and decodes Op/Funct into
//   write strobes and datapath selects. All control outputs are combinational
//   from state, Op, Funct, Zero and rst.
// Ports:
//   clk, rst (async, active-low)
//   Op, Funct  - instruction-register fields
//   Zero       - ALU zero flag (beq)
//   PCWrite, IRWrite, RegWrite, MemWrite - write strobes
//   EXTOp, ALUSrc, ALUOp, NPCOp, GPRSel, WDSel - datapath selects
//   state      - current FSM state
//   instr_done - retire pulse, identical to PCWrite
//   cyc_cnt, ret_cnt - performance counters
// Build option: define MC_CTRL_PERF_EN to build the cycle/retire counters;
//   without it both counter ports read constant 0 and carry no flops.
module mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             EXTOp,
  output logic             ALUSrc,
  output logic [3:0]       ALUOp,
  output logic [3:0]       NPCOp,
  output logic [1:0]       GPRSel,
  output logic [1:0]       WDSel,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] ret_cnt
);

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  state_t state_q;

  // Instruction decode
  logic is_r, is_jr, is_j, is_jal, is_beq, is_addi, is_ori, is_lw, is_sw;
  logic supported;
  logic [3:0] alu_op_dec;

  assign is_r    = (Op == 6'b000000);
  assign is_jr   = is_r && (Funct == 6'b001000);
  assign is_j    = (Op == 6'b000010);
  assign is_jal  = (Op == 6'b000011);
  assign is_beq  = (Op == 6'b000100);
  assign is_addi = (Op == 6'b001000);
  assign is_ori  = (Op == 6'b001101);
  assign is_lw   = (Op == 6'b100011);
  assign is_sw   = (Op == 6'b101011);
  assign supported = is_r | is_j | is_jal | is_beq | is_addi | is_ori | is_lw | is_sw;

  always_comb begin
    alu_op_dec = 4'd0;
    if (is_r) begin
      case (Funct)
        6'b100000: alu_op_dec = 4'd1;
        6'b100010: alu_op_dec = 4'd2;
        6'b100100: alu_op_dec = 4'd3;
        6'b100101: alu_op_dec = 4'd4;
        6'b101010: alu_op_dec = 4'd5;
        6'b000000: alu_op_dec = 4'd6;
        6'b000010: alu_op_dec = 4'd7;
        default:   alu_op_dec = 4'd0;
      endcase
    end else if (is_addi || is_lw || is_sw) begin
      alu_op_dec = 4'd1;
    end else if (is_ori) begin
      alu_op_dec = 4'd4;
    end else if (is_beq) begin
      alu_op_dec = 4'd2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IF;
    end else begin
      case (state_q)
        S_IF:    state_q <= S_ID;
        S_ID:    state_q <= (is_j || is_jal || !supported) ? S_IF : S_EX;
        S_EX: begin
          if (is_beq || is_jr)     state_q <= S_IF;
          else if (is_lw || is_sw) state_q <= S_MEM;
          else                     state_q <= S_WB;
        end
        S_MEM:   state_q <= is_lw ? S_WB : S_IF;
        S_WB:    state_q <= S_IF;
        default: state_q <= S_IF;
      endcase
    end
  end

  assign state = state_q;

  // rst gates every output so nothing strobes while the unit is held in reset,
  // even though the async reset already parks the state in IF.
  always_comb begin
    PCWrite  = 1'b0;
    IRWrite  = 1'b0;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    EXTOp    = 1'b0;
    ALUSrc   = 1'b0;
    ALUOp    = 4'd0;
    NPCOp    = 4'd0;
    GPRSel   = 2'd0;
    WDSel    = 2'd0;
    if (rst) begin
      // ALU selects are held from EX through WB so the ALU result stays valid
      // for address generation and write-back.
      if (state_q == S_EX || state_q == S_MEM || state_q == S_WB) begin
        ALUOp  = alu_op_dec;
        ALUSrc = is_addi | is_ori | is_lw;
        EXTOp  = is_addi | is_lw | is_sw | is_beq;
      end
      case (state_q)
        S_IF: IRWrite = 1'b1;
        S_ID: begin
          if (is_j || is_jal) begin
            PCWrite = 1'b1;
            NPCOp   = 4'd2;
            if (is_jal) begin
              RegWrite = 1'b1;
              GPRSel   = 2'd2;
              WDSel    = 2'd2;
            end
          end else if (!supported) begin
            PCWrite = 1'b1;
          end
        end
        S_EX: begin
          if (is_beq) begin
            PCWrite = 1'b1;
            NPCOp   = Zero ? 4'd1 : 4'd0;
          end else if (is_jr) begin
            PCWrite = 1'b1;
            NPCOp   = 4'd3;
          end
        end
        S_MEM: begin
          if (is_sw) begin
            MemWrite = 1'b1;
            PCWrite  = 1'b1;
          end
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          GPRSel   = (is_addi || is_ori || is_lw) ? 2'd1 : 2'd0;
          WDSel    = is_lw ? 2'd1 : 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign instr_done = PCWrite;

`ifdef MC_CTRL_PERF_EN
  logic [CNT_W-1:0] cyc_cnt_q;
  logic [CNT_W-1:0] ret_cnt_q;
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_q + ONE;
      if (instr_done) ret_cnt_q <= ret_cnt_q + ONE;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`else
  assign cyc_cnt = '0;
  assign ret_cnt = '0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
module tb_mc_ctrl;
  localparam int CNT_W = 4;
`ifdef MC_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int K_R = 0, K_JR = 1, K_J = 2, K_JAL = 3, K_BEQ = 4,
                 K_ADDI = 5, K_ORI = 6, K_LW = 7, K_SW = 8, K_NOP = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] Op = '0, Funct = '0;
  logic Zero = 1'b0;
  logic PCWrite, IRWrite, RegWrite, MemWrite, EXTOp, ALUSrc;
  logic [3:0] ALUOp, NPCOp;
  logic [1:0] GPRSel, WDSel;
  logic [2:0] state;
  logic instr_done;
  logic [CNT_W-1:0] cyc_cnt, ret_cnt;

  mc_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .Zero(Zero),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .EXTOp(EXTOp), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .NPCOp(NPCOp),
    .GPRSel(GPRSel), .WDSel(WDSel), .state(state), .instr_done(instr_done),
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] st;
    logic pcw, irw, rw, mw, ext, src;
    logic [3:0] aluop, npc;
    logic [1:0] gpr, wd;
  } ctrl_t;

  ctrl_t act;
  assign act = {state, PCWrite, IRWrite, RegWrite, MemWrite, EXTOp, ALUSrc,
                ALUOp, NPCOp, GPRSel, WDSel};

  ctrl_t exp_q[$];
  int checks = 0, errors = 0;
  int retired = 0;
  int cycles = 0;
  int mw_edges = 0;
  logic [5:0] rfun [7] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                           6'b101010, 6'b000000, 6'b000010};

  // Clock edges since reset release: the cycle counter's reference.
  always @(posedge clk or negedge rst)
    if (!rst) cycles <= 0; else cycles <= cycles + 1;

  always @(posedge clk) if (MemWrite === 1'b1) mw_edges <= mw_edges + 1;

  // ---------------- reference model ----------------
  function automatic int plen(input int k);
    case (k)
      K_J, K_JAL, K_NOP:         return 2;
      K_BEQ, K_JR:               return 3;
      K_R, K_ADDI, K_ORI, K_SW:  return 4;
      default:                   return 5; // lw
    endcase
  endfunction

  function automatic logic [2:0] path(input int k, input int s);
    if (s == 3) return (k == K_LW || k == K_SW) ? 3'd3 : 3'd4;
    return 3'(s);
  endfunction

  function automatic logic [3:0] alu_of(input int k, input logic [5:0] f);
    if (k == K_R) begin
      for (int i = 0; i < 7; i++) if (rfun[i] == f) return 4'(i + 1);
      return 4'd0;
    end
    if (k == K_ADDI || k == K_LW || k == K_SW) return 4'd1;
    if (k == K_ORI) return 4'd4;
    if (k == K_BEQ) return 4'd2;
    return 4'd0;
  endfunction

  task automatic push_instr(input int k, input logic [5:0] f, input logic z, input int upto);
    ctrl_t r;
    logic [2:0] st;
    int n;
    n = plen(k);
    for (int s = 0; s < n && s < upto; s++) begin
      st = path(k, s);
      r = '0;
      r.st  = st;
      r.irw = (st == 3'd0);
      r.pcw = (s == n - 1);
      if (s == n - 1) begin
        if (k == K_J || k == K_JAL) r.npc = 4'd2;
        else if (k == K_JR)         r.npc = 4'd3;
        else if (k == K_BEQ)        r.npc = z ? 4'd1 : 4'd0;
      end
      r.rw = (st == 3'd4) || (k == K_JAL && st == 3'd1);
      r.mw = (k == K_SW && st == 3'd3);
      if (st >= 3'd2) begin
        r.aluop = alu_of(k, f);
        r.src   = (k == K_ADDI || k == K_ORI || k == K_LW);
        r.ext   = (k == K_ADDI || k == K_LW || k == K_SW || k == K_BEQ);
      end
      if (st == 3'd4) begin
        r.gpr = (k == K_ADDI || k == K_ORI || k == K_LW) ? 2'd1 : 2'd0;
        r.wd  = (k == K_LW) ? 2'd1 : 2'd0;
      end
      if (k == K_JAL && st == 3'd1) begin
        r.gpr = 2'd2;
        r.wd  = 2'd2;
      end
      exp_q.push_back(r);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    ctrl_t e;
    if (!rst) begin
      exp_q.delete();
      retired = 0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL ctrl @%0t: got %h (state=%0d) required %h (state=%0d)",
                 $time, act, state, e, e.st);
      end
      checks++;
      if (cyc_cnt !== (PERF ? CNT_W'(cycles) : '0)) begin
        errors++;
        $display("FAIL cyc_cnt @%0t: got %0d required %0d", $time, cyc_cnt,
                 PERF ? CNT_W'(cycles) : 0);
      end
      checks++;
      if (ret_cnt !== (PERF ? CNT_W'(retired) : '0)) begin
        errors++;
        $display("FAIL ret_cnt @%0t: got %0d required %0d", $time, ret_cnt,
                 PERF ? CNT_W'(retired) : 0);
      end
      if (e.pcw) retired = retired + 1;
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1 with the DUT in IF.
  task automatic run_instr(input int k, input logic [5:0] op, input logic [5:0] f, input logic z);
    Op = op; Funct = f; Zero = z;
    push_instr(k, f, z, 99);
    repeat (plen(k)) @(posedge clk);
    #1;
  endtask

  task automatic rand_instr();
    int k;
    logic [5:0] op, f;
    k  = $urandom_range(0, 9);
    f  = 6'($urandom);
    op = 6'd0;
    case (k)
      K_R:    f = rfun[$urandom_range(0, 6)];
      K_JR:   f = 6'b001000;
      K_J:    op = 6'b000010;
      K_JAL:  op = 6'b000011;
      K_BEQ:  op = 6'b000100;
      K_ADDI: op = 6'b001000;
      K_ORI:  op = 6'b001101;
      K_LW:   op = 6'b100011;
      K_SW:   op = 6'b101011;
      default: begin
        do op = 6'($urandom);
        while (op inside {6'd0, 6'd2, 6'd3, 6'd4, 6'd8, 6'd13, 6'd35, 6'd43});
      end
    endcase
    run_instr(k, op, f, 1'($urandom));
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if ({PCWrite, IRWrite, RegWrite, MemWrite, EXTOp, ALUSrc, ALUOp, NPCOp, GPRSel, WDSel} !== '0
        || state !== 3'd0) begin
      errors++;
      $display("FAIL %s outputs: got state=%0d ctrl=%h required state=0 ctrl=0", tag, state, act);
    end
    checks++;
    if (cyc_cnt !== '0 || ret_cnt !== '0) begin
      errors++;
      $display("FAIL %s counters: got cyc=%0d ret=%0d required 0/0", tag, cyc_cnt, ret_cnt);
    end
  endtask

  int mw_snap;

  initial begin
    #1 rst = 1'b0;
    #1 check_reset("reset_async");
    @(posedge clk); #1 rst = 1'b1;

    // Directed: add, lw, beq taken/not taken, jal = 17 cycles from release.
    run_instr(K_R,   6'b000000, 6'b100000, 1'b0);
    run_instr(K_LW,  6'b100011, 6'b000000, 1'b0);
    run_instr(K_BEQ, 6'b000100, 6'b000000, 1'b1);
    run_instr(K_BEQ, 6'b000100, 6'b000000, 1'b0);
    run_instr(K_JAL, 6'b000011, 6'b000000, 1'b0);
    checks++;
    if (cyc_cnt !== (PERF ? 4'd1 : 4'd0)) begin
      errors++;
      $display("FAIL cyc_wrap17: got %0d required %0d", cyc_cnt, PERF ? 1 : 0);
    end
    checks++;
    if (ret_cnt !== (PERF ? 4'd5 : 4'd0)) begin
      errors++;
      $display("FAIL ret_after5: got %0d required %0d", ret_cnt, PERF ? 5 : 0);
    end

    // sw aborted by reset once it reaches MEM.
    mw_snap = mw_edges;
    Op = 6'b101011; Funct = 6'd0; Zero = 1'b0;
    push_instr(K_SW, 6'd0, 1'b0, 3);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_reset("reset_mid_sw");
    repeat (2) @(posedge clk);
    checks++;
    if (mw_edges != mw_snap) begin
      errors++;
      $display("FAIL sw_abort_memwrite: got %0d write edges required 0", mw_edges - mw_snap);
    end
    #1 rst = 1'b1;

    for (int i = 0; i < 300; i++) rand_instr();

    @(posedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
